// File: rtl/telemetry_tx.sv
// telemetry_tx
// Builds 6-byte status frames (header, distance hi/lo, angle, direction,
// checksum) and hands them one byte at a time to a UART transmitter using its
// start/finish handshake. Frames are started by send_req or by a free-running
// period timer, and only while enable is high.
//
// Ports:
//   sys_clk      system clock
//   rst          synchronous active-high reset
//   enable       gates new frames; a frame in flight always completes
//   send_req     one-cycle request for a frame
//   distance     12-bit ultrasonic distance
//   angle        8-bit servo angle code
//   direction    2-bit motor direction code
//   tx_finish    UART finish flag (async, low while the transmitter is busy)
//   tx_start     byte-start request to the UART
//   tx_data      byte being offered to the UART
//   frame_busy   high from LOAD until the frame ends or is aborted
//   frame_done   one-cycle pulse after the last byte completes
//   tx_timeout   one-cycle pulse when a handshake wait gives up
//   frame_count  completed frames, wraps at 16 bits
module telemetry_tx #(
    parameter int         PERIOD_CYCLES  = 10_000_000,
    parameter logic [7:0] HEADER         = 8'hA7,
    parameter int         TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        sys_clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        send_req,
    input  logic [11:0] distance,
    input  logic [7:0]  angle,
    input  logic [1:0]  direction,
    input  logic        tx_finish,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    output logic        frame_busy,
    output logic        frame_done,
    output logic        tx_timeout,
    output logic [15:0] frame_count
);

    localparam int PW = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [PW-1:0] PER_LAST = PW'(PERIOD_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_DONE, NEXT} state_t;

    state_t        state;
    logic          fin_meta, fin_s;
    logic [PW-1:0] per_cnt;
    logic          tick;
    logic          pending;
    logic          load_go;
    logic [2:0]    idx;
    logic [TW-1:0] wait_cnt;
    logic [3:0]    snap_dhi;
    logic [7:0]    snap_dlo;
    logic [7:0]    snap_ang;
    logic [1:0]    snap_dir;
    logic [7:0]    snap_ck;
    logic [7:0]    cur_byte;

    // tx_finish comes from another clock domain
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            fin_meta <= 1'b0;
            fin_s    <= 1'b0;
        end else begin
            fin_meta <= tx_finish;
            fin_s    <= fin_meta;
        end
    end

    // Period timer; held at zero while disabled so the first auto frame
    // comes a full period after enable rises.
    always_ff @(posedge sys_clk) begin
        if (rst || !enable || PERIOD_CYCLES == 0)
            per_cnt <= '0;
        else if (per_cnt == PER_LAST)
            per_cnt <= '0;
        else
            per_cnt <= per_cnt + PW'(1);
    end

    assign tick    = (PERIOD_CYCLES != 0) && enable && (per_cnt == PER_LAST);
    assign load_go = (state == IDLE) && pending && enable && fin_s;

    // A request landing in the same cycle as IDLE->LOAD is kept rather than
    // lost; it simply produces the next frame.
    always_ff @(posedge sys_clk) begin
        if (rst)
            pending <= 1'b0;
        else if ((send_req || tick) && enable)
            pending <= 1'b1;
        else if (load_go)
            pending <= 1'b0;
    end

    always_comb begin
        cur_byte = HEADER;
        case (idx)
            3'd1:    cur_byte = {4'b0, snap_dhi};
            3'd2:    cur_byte = snap_dlo;
            3'd3:    cur_byte = snap_ang;
            3'd4:    cur_byte = {6'b0, snap_dir};
            3'd5:    cur_byte = snap_ck;
            default: cur_byte = HEADER;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state       <= IDLE;
            tx_start    <= 1'b0;
            tx_data     <= 8'h00;
            frame_busy  <= 1'b0;
            frame_done  <= 1'b0;
            tx_timeout  <= 1'b0;
            frame_count <= 16'h0000;
            idx         <= 3'd0;
            wait_cnt    <= '0;
            snap_dhi    <= 4'h0;
            snap_dlo    <= 8'h00;
            snap_ang    <= 8'h00;
            snap_dir    <= 2'b00;
            snap_ck     <= 8'h00;
        end else begin
            frame_done <= 1'b0;
            tx_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    wait_cnt <= '0;
                    if (load_go) state <= LOAD;
                end
                LOAD: begin
                    snap_dhi   <= distance[11:8];
                    snap_dlo   <= distance[7:0];
                    snap_ang   <= angle;
                    snap_dir   <= direction;
                    snap_ck    <= {4'b0, distance[11:8]} + distance[7:0] + angle + {6'b0, direction};
                    idx        <= 3'd0;
                    frame_busy <= 1'b1;
                    wait_cnt   <= '0;
                    state      <= START;
                end
                START: begin
                    if (!fin_s) begin
                        // UART has taken the byte
                        tx_start <= 1'b0;
                        wait_cnt <= '0;
                        state    <= WAIT_DONE;
                    end else if (wait_cnt == TO_LAST) begin
                        tx_start   <= 1'b0;
                        frame_busy <= 1'b0;
                        tx_timeout <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        tx_start <= 1'b1;
                        tx_data  <= cur_byte;
                        wait_cnt <= wait_cnt + TW'(1);
                    end
                end
                WAIT_DONE: begin
                    if (fin_s) begin
                        state <= NEXT;
                    end else if (wait_cnt == TO_LAST) begin
                        frame_busy <= 1'b0;
                        tx_timeout <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + TW'(1);
                    end
                end
                NEXT: begin
                    wait_cnt <= '0;
                    if (idx == 3'd5) begin
                        frame_done  <= 1'b1;
                        frame_count <= frame_count + 16'd1;
                        frame_busy  <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        idx   <= idx + 3'd1;
                        state <= START;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_telemetry_tx.sv
module tb_telemetry_tx;

    logic        sys_clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        send_req;
    logic [11:0] distance;
    logic [7:0]  angle;
    logic [1:0]  direction;
    logic        tx_finish;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        frame_busy;
    logic        frame_done;
    logic        tx_timeout;
    logic [15:0] frame_count;

    logic        uart_stuck;
    logic [7:0]  rx_q[$];
    int          done_cnt = 0;
    int          to_cnt   = 0;
    int          errors   = 0;
    int          checks   = 0;

    localparam logic [47:0] FRAME_C8 = 48'hA7_01_F4_C8_03_C0;
    localparam logic [47:0] FRAME_96 = 48'hA7_01_F4_96_03_8E;

    always #5 sys_clk = ~sys_clk;

    telemetry_tx #(
        .PERIOD_CYCLES (5000),
        .HEADER        (8'hA7),
        .TIMEOUT_CYCLES(1000)
    ) dut (
        .sys_clk    (sys_clk),
        .rst        (rst),
        .enable     (enable),
        .send_req   (send_req),
        .distance   (distance),
        .angle      (angle),
        .direction  (direction),
        .tx_finish  (tx_finish),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .frame_busy (frame_busy),
        .frame_done (frame_done),
        .tx_timeout (tx_timeout),
        .frame_count(frame_count)
    );

    // UART model: finish falls 10 cycles after a start, rises 100 later
    initial begin
        tx_finish = 1'b1;
        forever begin
            @(negedge sys_clk);
            if (tx_start === 1'b1 && !uart_stuck) begin
                rx_q.push_back(tx_data);
                repeat (10) @(negedge sys_clk);
                tx_finish = 1'b0;
                repeat (100) @(negedge sys_clk);
                tx_finish = 1'b1;
            end
        end
    end

    always @(negedge sys_clk) begin
        if (frame_done === 1'b1) done_cnt++;
        if (tx_timeout === 1'b1) to_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_frame(input int off, input logic [47:0] exp, input string tag);
        for (int i = 0; i < 6; i++)
            chk($sformatf("%s_b%0d", tag, i),
                (off + i < rx_q.size()) ? {24'h0, rx_q[off + i]} : 32'hDEAD,
                {24'h0, exp[47 - 8 * i -: 8]});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge sys_clk);
        rst = 1'b0;
        repeat (3) @(negedge sys_clk);
    endtask

    task automatic pulse_req();
        send_req = 1'b1;
        @(negedge sys_clk);
        send_req = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget, input string tag);
        int n;
        n = 0;
        while (done_cnt < target && n < budget) begin
            @(negedge sys_clk);
            n++;
        end
        chk(tag, done_cnt, target);
    endtask

    task automatic wait_start(input logic lvl, input int budget, input string tag);
        int n;
        n = 0;
        while (tx_start !== lvl && n < budget) begin
            @(negedge sys_clk);
            n++;
        end
        chk(tag, tx_start, lvl);
    endtask

    task automatic wait_busy(input int budget, input string tag);
        int n;
        n = 0;
        while (frame_busy !== 1'b1 && n < budget) begin
            @(negedge sys_clk);
            n++;
        end
        chk(tag, frame_busy, 1);
    endtask

    task automatic wait_rxq(input int sz, input int budget, input string tag);
        int n;
        n = 0;
        while (rx_q.size() < sz && n < budget) begin
            @(negedge sys_clk);
            n++;
        end
        chk(tag, rx_q.size(), sz);
    endtask

    initial begin
        int base;
        int base_to;
        int w;

        uart_stuck = 1'b0;
        rst        = 1'b1;
        enable     = 1'b1;
        send_req   = 1'b0;
        distance   = 12'h1F4;
        angle      = 8'hC8;
        direction  = 2'b11;

        // reset state
        repeat (3) @(negedge sys_clk);
        chk("rst_tx_start", tx_start, 0);
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_busy", frame_busy, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_timeout", tx_timeout, 0);
        chk("rst_count", frame_count, 0);
        rst = 1'b0;
        repeat (3) @(negedge sys_clk);

        // single frame with latency
        do_reset();
        rx_q.delete();
        base = done_cnt;
        pulse_req();
        @(negedge sys_clk);
        chk("lat_busy_1", frame_busy, 0);
        @(negedge sys_clk);
        chk("lat_busy_2", frame_busy, 1);
        chk("lat_start_2", tx_start, 0);
        @(negedge sys_clk);
        chk("lat_start_3", tx_start, 1);
        chk("lat_data_3", tx_data, 8'hA7);
        wait_done(base + 1, 2000, "f1_done");
        chk_frame(0, FRAME_C8, "f1");
        chk("f1_count", frame_count, 1);
        repeat (300) @(negedge sys_clk);
        chk("f1_single_done", done_cnt, base + 1);

        // atomic snapshot
        do_reset();
        rx_q.delete();
        base = done_cnt;
        pulse_req();
        wait_rxq(2, 1000, "snap_b1_seen");
        wait_start(1'b0, 200, "snap_b1_acc");
        angle = 8'h96;
        pulse_req();
        wait_done(base + 2, 3000, "snap_done");
        chk_frame(0, FRAME_C8, "snap_f1");
        chk_frame(6, FRAME_96, "snap_f2");
        chk("snap_count", frame_count, 2);
        angle = 8'hC8;

        // coalescing
        do_reset();
        base = done_cnt;
        pulse_req();
        wait_busy(20, "coal_busy");
        repeat (100) @(negedge sys_clk);
        for (int i = 0; i < 3; i++) begin
            pulse_req();
            repeat (50) @(negedge sys_clk);
        end
        chk("coal_mid_busy", frame_busy, 1);
        wait_done(base + 2, 3000, "coal_done");
        repeat (1500) @(negedge sys_clk);
        chk("coal_no_third", done_cnt, base + 2);
        chk("coal_count", frame_count, 2);

        // timeout with finish stuck high
        do_reset();
        base    = done_cnt;
        base_to = to_cnt;
        uart_stuck = 1'b1;
        pulse_req();
        wait_start(1'b1, 20, "to_start_up");
        repeat (900) @(negedge sys_clk);
        chk("to_start_held", tx_start, 1);
        chk("to_busy_held", frame_busy, 1);
        w = 0;
        while (tx_start === 1'b1 && w < 300) begin
            @(negedge sys_clk);
            w++;
        end
        chk("to_fall_window", (w >= 95 && w <= 105), 1);
        chk("to_busy_drop", frame_busy, 0);
        repeat (5) @(negedge sys_clk);
        chk("to_pulse", to_cnt - base_to, 1);
        chk("to_no_done", done_cnt - base, 0);
        chk("to_count", frame_count, 0);
        repeat (100) @(negedge sys_clk);
        chk("to_no_restart", tx_start, 0);
        uart_stuck = 1'b0;
        rx_q.delete();
        pulse_req();
        wait_done(base + 1, 2000, "to_retry_done");
        chk_frame(0, FRAME_C8, "to_retry");
        chk("to_retry_count", frame_count, 1);
        chk("to_single_pulse", to_cnt - base_to, 1);

        // automatic period
        do_reset();
        base = done_cnt;
        repeat (19900) @(negedge sys_clk);
        chk("auto_three", done_cnt - base, 3);
        chk("auto_count3", frame_count, 3);
        wait_busy(400, "auto_fourth_start");
        enable = 1'b0;
        wait_done(base + 4, 1500, "auto_fourth_done");
        repeat (11000) @(negedge sys_clk);
        chk("auto_stopped", done_cnt - base, 4);
        chk("auto_idle", frame_busy, 0);
        chk("auto_count4", frame_count, 4);

        // send_req ignored while disabled
        base = done_cnt;
        pulse_req();
        repeat (300) @(negedge sys_clk);
        chk("ign_busy", frame_busy, 0);
        enable = 1'b1;
        repeat (300) @(negedge sys_clk);
        chk("ign_no_late", frame_busy, 0);
        chk("ign_no_done", done_cnt - base, 0);

        // reset mid-frame
        do_reset();
        rx_q.delete();
        base = done_cnt;
        pulse_req();
        wait_done(base + 1, 2000, "rmid_f1");
        chk("rmid_count1", frame_count, 1);
        pulse_req();
        wait_rxq(10, 2000, "rmid_b3_seen");
        base = done_cnt;
        rst = 1'b1;
        @(negedge sys_clk);
        chk("rmid_start", tx_start, 0);
        chk("rmid_busy", frame_busy, 0);
        chk("rmid_count0", frame_count, 0);
        rst = 1'b0;
        repeat (400) @(negedge sys_clk);
        chk("rmid_no_done", done_cnt, base);
        rx_q.delete();
        pulse_req();
        wait_done(base + 1, 2000, "rmid_retry_done");
        chk_frame(0, FRAME_C8, "rmid_retry");
        chk("rmid_count_after", frame_count, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/telemetry_tx.md
Name: telemetry_tx

Overview:
Builds fixed-length status frames (ultrasonic distance, servo angle, motor direction) and feeds them byte by byte into the UART transmitter. It is the reverse direction of the UART command decoder, which consumes host command bytes with low bits 2'b00. Telemetry frames use a header byte whose low bits are 2'b11, so the host can tell them apart from command traffic. The block runs on sys_clk and sits between the status registers and the UART_TX start/finish handshake.

Parameters:
PERIOD_CYCLES, 10_000_000, sys_clk cycles between automatic frames (10 Hz at 100 MHz); 0 disables the auto timer
HEADER, 8'hA7, frame start byte; low 2 bits must be 2'b11
TIMEOUT_CYCLES, 1_000_000, maximum sys_clk cycles spent in any handshake wait before the frame is aborted

Ports:
sys_clk  in  1  system clock (100 MHz)
rst  in  1  synchronous, active-high reset
enable  in  1  when low, no new frame starts; a frame already in progress completes
send_req  in  1  single-cycle request for one frame (in addition to the timer)
distance  in  12  ultrasonic distance
angle  in  8  servo angle code
direction  in  2  motor direction code
tx_finish  in  1  UART_TX finish flag; asynchronous to sys_clk, low while the transmitter is busy
tx_start  out  1  byte-start request to UART_TX
tx_data  out  8  byte to transmit
frame_busy  out  1  high from LOAD until the frame ends
frame_done  out  1  1-cycle pulse after the last byte completes
tx_timeout  out  1  1-cycle pulse when a frame is aborted
frame_count  out  16  count of completed frames; wraps from 16'hFFFF to 0

Behaviour:
- Reset (synchronous, active-high): tx_start=0, tx_data=8'h00, frame_busy=0, frame_done=0, tx_timeout=0, frame_count=0. Period timer, pending flag and byte index are cleared, and the FSM goes to IDLE. Reset during a frame abandons it without a frame_done pulse.
- tx_finish passes through a 2-flop synchronizer (fin_s) before the FSM uses it.
- Period timer: counts 0..PERIOD_CYCLES-1 while enable=1; at wrap it asserts an internal tick. It holds at 0 while enable=0.
- pending flag:
  - set by (send_req | tick) & enable;
  - cleared on IDLE->LOAD;
  - several requests arriving during one frame coalesce into one pending frame.
- Frame layout, 6 bytes, sent in this order:
  - B0 = HEADER
  - B1 = {4'b0, distance[11:8]}
  - B2 = distance[7:0]
  - B3 = angle
  - B4 = {6'b0, direction}
  - B5 = (B1+B2+B3+B4) mod 256
- All fields are snapshotted in LOAD, so a frame is atomic even if the inputs change mid-frame.
- FSM states: IDLE, LOAD, START, WAIT_DONE, NEXT.
  - IDLE: if pending & enable & fin_s, go to LOAD. The fin_s condition means no frame starts while UART_TX is still busy.
  - LOAD: snapshot fields, compute checksum, idx=0, frame_busy=1; go to START. This costs 1 cycle.
  - START: tx_data=byte[idx], tx_start=1. Hold until fin_s=0 (byte accepted), then tx_start=0 and go to WAIT_DONE.
  - WAIT_DONE: wait for fin_s=1, then go to NEXT.
  - NEXT: if idx==5, pulse frame_done, frame_count+1, frame_busy=0, go to IDLE. Otherwise idx+1 and go to START.
- tx_data is stable while tx_start=1 and until fin_s falls.
- Timeout:
  - A wait counter resets on every state entry and counts in START and WAIT_DONE.
  - Reaching TIMEOUT_CYCLES pulses tx_timeout, drops tx_start and frame_busy, and returns to IDLE.
  - frame_count is not incremented; the pending flag keeps its value.
- Simultaneous send_req and tick: one request.
- send_req while enable=0: ignored.
- enable falling mid-frame: the frame finishes; pending is kept but cannot start a frame until enable=1.
- frame_count wrap: 16'hFFFF + 1 = 16'h0000, with frame_done still pulsing.
- Latency: send_req in IDLE (with fin_s=1) gives frame_busy=1 two cycles later and tx_start=1 three cycles later.

Test Plan:
- Single-frame bytes: distance=12'h1F4, angle=8'hC8, direction=2'b11, send_req pulse, UART model answering each start (finish low 10 cycles later, high 100 cycles after that) -> bytes A7,01,F4,C8,03,C0; one frame_done; frame_count=1.
- Atomic snapshot: change angle to 8'h96 after B1 is accepted -> B3 still C8 and checksum C0; the next frame carries 96 with checksum 8E.
- Request coalescing: three send_req pulses during one frame -> exactly one extra frame follows; frame_count=2.
- Timeout: tx_finish stuck high with TIMEOUT_CYCLES=1000 -> tx_start falls after 1000 cycles; one tx_timeout pulse; frame_count unchanged; retry starts once pending is serviced.
- Auto period and enable: PERIOD_CYCLES=5000 with enable=1 for 20000 cycles -> 4 frames; enable=0 mid-frame -> that frame completes and no further frames start.
- Reset mid-frame: rst during B3 -> next cycle tx_start=0, frame_busy=0, frame_count=0, no frame_done; after release, send_req yields a full frame from A7.
